nrf_tx_sequencer: RTL and testbench

//  Frame-level sequencer that sits directly upstream of the SPI byte transmitter.
//  - Buffers payload bytes in an internal FIFO.
//  - On request, issues one nRF24L01 command byte followed by the buffered payload,

---
 rtl/nrf_tx_sequencer_pkg.sv | 21 ++
 rtl/nrf_tx_sequencer_if.sv | 21 ++
 rtl/nrf_tx_sequencer_byte_fifo.sv | 50 +++++
 rtl/nrf_tx_sequencer.sv | 156 +++++++++++++++
 tb/tb_nrf_tx_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrf_tx_sequencer_pkg.sv
// Shared constants for the nRF24L01 frame sequencer:
// radio command bytes and the FSM state encoding.
package nrf_pkg;

  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] R_REGISTER   = 8'h00;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] NOP          = 8'hFF;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CMD  = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_GAPW = 3'd3;
  localparam state_t S_DATA = 3'd4;
  localparam state_t S_CEP  = 3'd5;
  localparam state_t S_DONE = 3'd6;

endpackage

// File: rtl/nrf_tx_sequencer_if.sv
// Byte handshake between sequencer (master) and the
// SPI byte transmitter (slave): start_tx, data_in, done_tx.
interface nrf_tx_sequencer_if;

  logic       start_tx;
  logic [7:0] data_in;
  logic       done_tx;

  modport master (
    output start_tx,
    output data_in,
    input  done_tx
  );

  modport slave (
    input  start_tx,
    input  data_in,
    output done_tx
  );

endinterface

// File: rtl/nrf_tx_sequencer_byte_fifo.sv
// Payload byte FIFO: push one byte, pop 0..DEPTH bytes per cycle.
// Ports: push/wr_data in, pop_cnt in, rd_data/level/full/empty out.
module byte_fifo
  import nrf_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH):0]   pop_cnt,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;

  assign wr_ok   = push && !full;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // A multi-byte pop drops a whole frame
  // remainder in one cycle after a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + pop_cnt[AW-1:0];
      level  <= level + LW'(wr_ok) - pop_cnt;
    end
  end

endmodule

// File: rtl/nrf_tx_sequencer.sv
// Frame sequencer: sends cmd + buffered payload byte by byte,
// then optionally pulses CE. Ports: FIFO write, frame control, tx if.
module nrf_tx_sequencer
  import nrf_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int GAP      = 2,
  parameter int CE_PULSE = 120,
  parameter int TIMEOUT  = 16
) (
  input  logic                   clk_10,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  input  logic                   frame_start,
  input  logic [7:0]             cmd,
  input  logic                   ce_after,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic                   ce,
  nrf_tx_sequencer_if.master     tx
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(CE_PULSE + TIMEOUT + GAP) + 1;

  state_t        state;
  logic          ce_af;
  logic [LW-1:0] len;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;
  logic [7:0]    rd_data;
  logic [LW-1:0] pop_cnt;
  logic          fifo_empty;
  logic          accept;
  logic          done;
  logic          tmo;
  logic          gap_end;
  logic          more;
  logic          ovf;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_10),
    .rst_n   (rst_n),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop_cnt (pop_cnt),
    .rd_data (rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign accept  = (state == S_IDLE) && frame_start;
  assign done    = tx.done_tx;
  assign tmo     = (state == S_WAIT) && !done
                && (cnt == '0);
  assign gap_end = (state == S_GAPW) && (cnt == '0);
  assign more    = (len != '0) && !fifo_empty;
  assign ovf     = wr_en && fifo_full;

  // Head byte leaves the FIFO as it is loaded into
  // data_in; a timeout drops what is left of the frame.
  always_comb begin
    pop_cnt = '0;
    unique case (1'b1)
      gap_end: pop_cnt = LW'(1);
      tmo:     pop_cnt = len;
      default: pop_cnt = '0;
    endcase
  end

  // One down-counter serves gap, timeout and CE timing.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ce_af  <= 1'b0;
      len    <= '0;
      cnt    <= '0;
      data_q <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            state  <= S_CMD;
            data_q <= cmd;
            ce_af  <= ce_after;
            len    <= fifo_level;
          end
        end
        S_CMD: begin
          state <= S_WAIT;
          cnt   <= CW'(TIMEOUT - 2);
        end
        S_DATA: begin
          state <= S_WAIT;
          cnt   <= CW'(TIMEOUT - 2);
          len   <= len - LW'(1);
        end
        S_WAIT: begin
          if (done) begin
            if (more) begin
              state <= S_GAPW;
              cnt   <= CW'(GAP - 1);
            end else if (ce_af) begin
              state <= S_CEP;
              cnt   <= CW'(CE_PULSE - 1);
            end else begin
              state <= S_DONE;
            end
          end else if (cnt == '0) begin
            state <= S_DONE;
            len   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_GAPW: begin
          if (cnt == '0) begin
            state  <= S_DATA;
            data_q <= rd_data;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CEP: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky: a new error in the accept cycle wins.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n)          err <= 1'b0;
    else if (ovf || tmo) err <= 1'b1;
    else if (accept)     err <= 1'b0;
  end

  assign busy        = (state != S_IDLE)
                    && (state != S_DONE);
  assign frame_done  = (state == S_DONE);
  assign ce          = (state == S_CEP);
  assign tx.start_tx = (state == S_CMD)
                    || (state == S_DATA);
  assign tx.data_in  = data_q;

endmodule

// File: tb/tb_nrf_tx_sequencer.sv
// Self-checking bench for nrf_tx_sequencer: queue model of the
// payload FIFO, byte transmitter model with 9-cycle done_tx.
module tb_nrf_tx_sequencer;

  localparam int DEPTH    = 32;
  localparam int GAP      = 2;
  localparam int CE_PULSE = 120;
  localparam int TIMEOUT  = 16;

  logic       clk_10 = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full;
  logic [5:0] fifo_level;
  logic       frame_start = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       ce_after = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       err;
  logic       ce;

  nrf_tx_sequencer_if txi ();

  nrf_tx_sequencer #(
    .DEPTH    (DEPTH),
    .GAP      (GAP),
    .CE_PULSE (CE_PULSE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_10      (clk_10),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .frame_start (frame_start),
    .cmd         (cmd),
    .ce_after    (ce_after),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err),
    .ce          (ce),
    .tx          (txi)
  );

  always #50 clk_10 = ~clk_10;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic       merr = 1'b0;
  bit         resp_en = 1'b1;
  int st_cyc = 0;
  int fd_cyc = 0;
  int ce_cnt = 0;
  int fd_cnt = 0;
  int gap_n = 0;
  int gap_bad = 0;
  int last_done = -1;

  initial forever begin
    @(posedge clk_10);
    cyc++;
  end

  // Byte transmitter: done_tx 9 cycles after start_tx.
  initial begin
    txi.done_tx = 1'b0;
    forever begin
      @(negedge clk_10);
      if (txi.start_tx && resp_en) begin
        repeat (9) @(posedge clk_10);
        #1 txi.done_tx = 1'b1;
        @(posedge clk_10);
        #1 txi.done_tx = 1'b0;
      end
    end
  end

  // Observer of the tx side, CE and frame_done.
  initial forever begin
    @(negedge clk_10);
    if (txi.start_tx) begin
      sent.push_back(txi.data_in);
      st_cyc = cyc;
      if (last_done >= 0) begin
        gap_n++;
        if (cyc - last_done != GAP + 1) gap_bad++;
      end
    end
    if (txi.done_tx) last_done = cyc;
    if (ce) ce_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_10);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(b);
    else merr = 1'b1;
  endtask

  task automatic run_frame(input string tag,
                           input logic [7:0] c,
                           input logic cea,
                           input bit resp,
                           input bit wp,
                           input logic [7:0] pb,
                           input bit dup);
    logic [7:0] exp[$];
    logic [7:0] b;
    int n;
    n = mq.size();
    exp = {};
    exp.push_back(c);
    for (int i = 0; i < n; i++) begin
      b = mq.pop_front();
      if (resp) exp.push_back(b);
    end
    if (wp) mq.push_back(pb);
    merr = !resp;
    sent = {};
    ce_cnt = 0;
    fd_cnt = 0;
    gap_n = 0;
    gap_bad = 0;
    last_done = -1;
    resp_en = resp;
    cmd = c;
    ce_after = cea;
    frame_start = 1'b1;
    wr_en = wp;
    wr_data = pb;
    tick();
    frame_start = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_start_tx"}, 32'(txi.start_tx), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_cmd_byte"}, 32'(txi.data_in), 32'(c));
    if (dup) begin
      cmd = ~c;
      ce_after = !cea;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    for (int t = 0; t < 3000 && frame_done !== 1'b1; t++)
      @(negedge clk_10);
    chk({tag, "_frame_done"}, 32'(frame_done), 1);
    chk({tag, "_err"}, 32'(err), 32'(merr));
    chk({tag, "_level"}, 32'(fifo_level), mq.size());
    repeat (4) tick();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_nbytes"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent.size(); i++)
      chk({tag, "_byte"}, 32'(sent[i]), 32'(exp[i]));
    chk({tag, "_ce_cycles"}, ce_cnt,
        (resp && cea) ? CE_PULSE : 0);
    chk({tag, "_done_pulses"}, fd_cnt, 1);
    if (resp) begin
      chk({tag, "_gap_count"}, gap_n, n);
      chk({tag, "_gap_bad"}, gap_bad, 0);
    end else begin
      chk({tag, "_timeout"}, fd_cyc - st_cyc, TIMEOUT);
    end
    resp_en = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start_tx", 32'(txi.start_tx), 0);
    chk("rst_data_in", 32'(txi.data_in), 0);
    chk("rst_ce", 32'(ce), 0);
    rst_n = 1'b1;
    tick();

    // 1: three bytes with CE pulse
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("t1_level", 32'(fifo_level), 3);
    run_frame("t1", 8'hA0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // 3: transmitter never answers
    for (int i = 0; i < 3; i++)
      push(8'($urandom_range(0, 255)));
    run_frame("t3", 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_err_sticky", 32'(err), 1);

    // 2: zero-length frame, also clears err
    run_frame("t2", 8'hE1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 4: overflow
    for (int i = 0; i < DEPTH; i++)
      push(8'($urandom_range(0, 255)));
    chk("t4_full", 32'(fifo_full), 1);
    chk("t4_level32", 32'(fifo_level), DEPTH);
    chk("t4_err_before", 32'(err), 0);
    push(8'($urandom_range(0, 255)));
    chk("t4_err_ovf", 32'(err), 32'(merr));
    chk("t4_level_kept", 32'(fifo_level), DEPTH);
    run_frame("t4", 8'hA0, 1'($urandom_range(0, 1)),
              1'b1, 1'b0, 8'h00, 1'b0);

    // 5: write with frame_start, request while busy
    push(8'h01);
    run_frame("t5", 8'($urandom_range(0, 255)), 1'b0,
              1'b1, 1'b1, 8'h55, 1'b1);

    // random frames
    for (int f = 0; f < 4; f++) begin
      int k;
      k = $urandom_range(0, 5);
      for (int i = 0; i < k; i++)
        push(8'($urandom_range(0, 255)));
      run_frame("rnd", 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)),
                1'b1, 1'b0, 8'h00, 1'b0);
    end

    // 6: reset during CE pulse
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    cmd = 8'hA0;
    ce_after = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int t = 0; t < 400 && ce !== 1'b1; t++) tick();
    chk("t6_cep_seen", 32'(ce), 1);
    push(8'h77);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_ce", 32'(ce), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_start_tx", 32'(txi.start_tx), 0);
    chk("t6_level", 32'(fifo_level), 0);
    mq = {};
    merr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_after_ce", 32'(ce), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
